axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI data width; only 32 is supported.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 7: AXI address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: abort limit in cycles, minimum 2.
REQ-004 SHALL have port M_AXI_ACLK, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port M_AXI_ARESET, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, C_M_AXI_ADDR_WIDTH: byte address.
REQ-010 SHALL have port cmd_wdata, input, 32: write data.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 32: read data, held until the next accepted command.
REQ-013 SHALL have port rsp_resp, output, 2: captured BRESP or RRESP.
REQ-014 SHALL have port rsp_timeout, output, 1: the completed command was aborted.
REQ-015 SHALL have port M_AXI_AWADDR, output, C_M_AXI_ADDR_WIDTH.
REQ-016 SHALL have port M_AXI_AWVALID, output, 1.
REQ-017 SHALL have port M_AXI_AWREADY, input, 1.
REQ-018 SHALL have port M_AXI_WDATA, output, 32.
REQ-019 SHALL have port M_AXI_WSTRB, output, 4: constant 4'hF.
REQ-020 SHALL have port M_AXI_WVALID, output, 1.
REQ-021 SHALL have port M_AXI_WREADY, input, 1.
REQ-022 SHALL have port M_AXI_BRESP, input, 2.
REQ-023 SHALL have port M_AXI_BVALID, input, 1.
REQ-024 SHALL have port M_AXI_BREADY, output, 1.
REQ-025 SHALL have port M_AXI_ARADDR, output, C_M_AXI_ADDR_WIDTH.
REQ-026 SHALL have port M_AXI_ARVALID, output, 1.
REQ-027 SHALL have port M_AXI_ARREADY, input, 1.
REQ-028 SHALL have port M_AXI_RDATA, input, 32.
REQ-029 SHALL have port M_AXI_RRESP, input, 2.
REQ-030 SHALL have port M_AXI_RVALID, input, 1.
REQ-031 SHALL have port M_AXI_RREADY, output, 1.

Function
REQ-032 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA; cmd_ready = (state==IDLE), registered.
REQ-033 On accept, SHALL latch addr/wdata into AW/W/AR registers, enter WRITE (cmd_write=1) or RADDR, and assert AWVALID+WVALID or ARVALID the next cycle.
REQ-034 In WRITE, SHALL drop AWVALID and WVALID independently on their own handshake; enter WRESP with BREADY=1 after both complete, including the same-cycle case.
REQ-035 In WRESP, on BVALID: SHALL capture BRESP, clear BREADY, pulse rsp_valid, return to IDLE.
REQ-036 In RADDR, on ARREADY: SHALL clear ARVALID, set RREADY, enter RDATA.
REQ-037 In RDATA, on RVALID: SHALL capture RDATA/RRESP, clear RREADY, pulse rsp_valid, return to IDLE.
REQ-038 SHALL never assert VALID combinationally from READY, and SHALL hold AW/W/AR address and data stable while VALID is high.
REQ-039 Timeout counter SHALL clear on accept and increment each non-IDLE cycle.
REQ-040 At count TIMEOUT_CYCLES-1, SHALL deassert all VALID/READY, pulse rsp_valid with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0, and go to IDLE.
REQ-041 A completing handshake in the timeout cycle SHALL take priority (normal response).
REQ-042 cmd_valid outside IDLE SHALL be ignored; one outstanding transaction maximum.

Reset
REQ-043 On M_AXI_ARESET=1, SHALL asynchronously enter IDLE with all AXI VALID/READY=0, cmd_ready=0, rsp_valid=0, rsp_timeout=0, rsp_resp=0, rsp_rdata=0, addresses/data=0.
REQ-044 SHALL set cmd_ready=1 on the first clock after reset release; reset mid-transaction SHALL abandon it without a rsp_valid pulse.

Verification
REQ-045 Write 0x54 data 0x0000_1234, slave AWREADY=WREADY=1, BRESP=0 -> one AW and one W handshake, rsp_valid one cycle, rsp_resp=0, rsp_timeout=0.
REQ-046 Read 0x44, slave returns RDATA=0x11A6EBF8 after 3 cycles -> rsp_rdata=0x11A6EBF8, rsp_resp=0, one rsp_valid pulse.
REQ-047 Write with WREADY 2 cycles before AWREADY -> WVALID drops first, AWVALID stays until its handshake, then exactly one BREADY handshake.
REQ-048 Read, slave never asserts ARREADY, TIMEOUT_CYCLES=16 -> rsp_valid 16 cycles after accept, rsp_timeout=1, rsp_resp=2'b10, ARVALID=0 afterwards.
REQ-049 Reset asserted during RDATA -> RREADY=0 immediately, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into an AXI
// write or read, and reports the response or a timeout abort on rsp_*.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                          state_r, state_s;
  logic [CNT_W-1:0]                cnt_r, cnt_s;
  logic                            cmd_ready_r, cmd_ready_s;
  logic                            awvalid_r, awvalid_s;
  logic                            wvalid_r, wvalid_s;
  logic                            bready_r, bready_s;
  logic                            arvalid_r, arvalid_s;
  logic                            rready_r, rready_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_r, awaddr_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_r, araddr_s;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic                            rsp_valid_r, rsp_valid_s;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic [1:0]                      rsp_resp_r, rsp_resp_s;
  logic                            rsp_timeout_r, rsp_timeout_s;
  logic                            aw_done_s, w_done_s, finishing_s, expired_s;

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    arvalid_s     = arvalid_r;
    rready_s      = rready_r;
    awaddr_s      = awaddr_r;
    araddr_s      = araddr_r;
    wdata_s       = wdata_r;
    rsp_valid_s   = 1'b0;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;

    // A channel is done once its VALID has been dropped or is handshaking now
    aw_done_s   = !awvalid_r || M_AXI_AWREADY;
    w_done_s    = !wvalid_r || M_AXI_WREADY;
    finishing_s = ((state_r == WRESP) && M_AXI_BVALID) ||
                  ((state_r == RDATA) && M_AXI_RVALID);
    expired_s   = (state_r != IDLE) && (cnt_r == CNT_LAST);

    if (expired_s && !finishing_s) begin
      state_s       = IDLE;
      awvalid_s     = 1'b0;
      wvalid_s      = 1'b0;
      bready_s      = 1'b0;
      arvalid_s     = 1'b0;
      rready_s      = 1'b0;
      rsp_valid_s   = 1'b1;
      rsp_timeout_s = 1'b1;
      rsp_resp_s    = 2'b10;
      rsp_rdata_s   = {C_M_AXI_DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cnt_s    = {CNT_W{1'b0}};
            awaddr_s = cmd_addr;
            araddr_s = cmd_addr;
            wdata_s  = cmd_wdata;
            if (cmd_write) begin
              state_s   = WRITE;
              awvalid_s = 1'b1;
              wvalid_s  = 1'b1;
            end else begin
              state_s   = RADDR;
              arvalid_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WRITE: begin
          cnt_s = cnt_r + CNT_W'(1);
          if (awvalid_r && M_AXI_AWREADY) begin
            awvalid_s = 1'b0;
          end else begin
            awvalid_s = awvalid_r;
          end
          if (wvalid_r && M_AXI_WREADY) begin
            wvalid_s = 1'b0;
          end else begin
            wvalid_s = wvalid_r;
          end
          if (aw_done_s && w_done_s) begin
            state_s  = WRESP;
            bready_s = 1'b1;
          end else begin
            state_s = WRITE;
          end
        end
        WRESP: begin
          cnt_s = cnt_r + CNT_W'(1);
          if (M_AXI_BVALID) begin
            state_s       = IDLE;
            bready_s      = 1'b0;
            rsp_valid_s   = 1'b1;
            rsp_resp_s    = M_AXI_BRESP;
            rsp_timeout_s = 1'b0;
          end else begin
            state_s = WRESP;
          end
        end
        RADDR: begin
          cnt_s = cnt_r + CNT_W'(1);
          if (M_AXI_ARREADY) begin
            state_s   = RDATA;
            arvalid_s = 1'b0;
            rready_s  = 1'b1;
          end else begin
            state_s = RADDR;
          end
        end
        RDATA: begin
          cnt_s = cnt_r + CNT_W'(1);
          if (M_AXI_RVALID) begin
            state_s       = IDLE;
            rready_s      = 1'b0;
            rsp_valid_s   = 1'b1;
            rsp_rdata_s   = M_AXI_RDATA;
            rsp_resp_s    = M_AXI_RRESP;
            rsp_timeout_s = 1'b0;
          end else begin
            state_s = RDATA;
          end
        end
        default: begin
          state_s   = IDLE;
          awvalid_s = 1'b0;
          wvalid_s  = 1'b0;
          bready_s  = 1'b0;
          arvalid_s = 1'b0;
          rready_s  = 1'b0;
        end
      endcase
    end

    cmd_ready_s = (state_s == IDLE);
  end

  // State and registered-output update with asynchronous reset
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      cmd_ready_r   <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      awaddr_r      <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      araddr_r      <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      wdata_r       <= {C_M_AXI_DATA_WIDTH{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {C_M_AXI_DATA_WIDTH{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      cmd_ready_r   <= cmd_ready_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      awaddr_r      <= awaddr_s;
      araddr_r      <= araddr_s;
      wdata_r       <= wdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: a scheduled AXI slave plus a
// transaction-level model predicting handshake windows, latency and response.
module tb_axi_lite_cmd_master;
  localparam int AW = 7;
  localparam int T  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata_in;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata_in), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // One outstanding transaction as the model sees it; k counts edges after accept
  typedef struct {
    int acc; int kd; bit wr; bit to; int aw; int w; int a;
    logic [1:0] resp; logic [31:0] rdata; logic [6:0] addr; logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          chk_en = 1'b0;
  int          last_acc = 0, last_cyc = -1;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;
  logic        last_to;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Completion edge and abort flag from the slave schedule (edge indices after accept)
  function automatic void predict(input bit wr, input int aw, input int w, input int b,
                                  input int a, input int r, output int kd, output bit to);
    int m;
    m = (aw > w) ? aw : w;
    if (wr ? (m < T && b <= T) : (a < T && r <= T)) begin
      kd = wr ? b : r;
      to = 1'b0;
    end else begin
      kd = T;
      to = 1'b1;
    end
  endfunction

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    int k, m;
    logic [4:0] vec, exp_vec;
    if (chk_en && !rst) begin
      vec = {awvalid, wvalid, bready, arvalid, rready};
      check("wstrb", {28'd0, wstrb}, 32'hF);
      if (q.size() == 0) begin
        check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_handshakes", {27'd0, vec}, 32'd0);
      end else begin
        k = cyc - q[0].acc + 1;
        m = (q[0].aw > q[0].w) ? q[0].aw : q[0].w;
        if (k == q[0].kd + 1) begin
          check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
          check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, q[0].to});
          check("rsp_resp", {30'd0, rsp_resp}, q[0].to ? 32'd2 : {30'd0, q[0].resp});
          if (q[0].to) check("rsp_rdata_abort", rsp_rdata, 32'd0);
          else if (!q[0].wr) check("rsp_rdata", rsp_rdata, q[0].rdata);
          check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
          check("done_handshakes", {27'd0, vec}, 32'd0);
          last_cyc = cyc; last_rdata = rsp_rdata; last_resp = rsp_resp; last_to = rsp_timeout;
          void'(q.pop_front());
        end else begin
          if (q[0].wr) exp_vec = {k <= q[0].aw, k <= q[0].w, k > m, 1'b0, 1'b0};
          else         exp_vec = {3'b000, k <= q[0].a, k > q[0].a};
          check("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
          check("busy_handshakes", {27'd0, vec}, {27'd0, exp_vec});
          if (awvalid) check("awaddr", {25'd0, awaddr}, {25'd0, q[0].addr});
          if (wvalid)  check("wdata", wdata, q[0].wdata);
          if (arvalid) check("araddr", {25'd0, araddr}, {25'd0, q[0].addr});
        end
      end
    end
  end

  task automatic clear_inputs();
    cmd_valid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0;
  endtask

  // Issue one command and play the slave from its edge schedule; rst_at>0 resets mid-flight
  task automatic run_txn(input bit wr, input logic [6:0] addr, input logic [31:0] wd,
                         input int aw, input int w, input int b, input int a, input int r,
                         input logic [1:0] resp, input logic [31:0] rd, input int rst_at);
    int kd, guard, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit to, b_done, r_done;
    exp_t e;
    predict(wr, aw, w, b, a, r, kd, to);
    guard = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    b_done = 1'b0; r_done = 1'b0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk);
    #1;
    e = '{acc: cyc, kd: kd, wr: wr, to: to, aw: aw, w: w, a: a,
          resp: resp, rdata: rd, addr: addr, wdata: wd};
    q.push_back(e);
    last_acc = cyc;
    for (int k = 1; k <= kd; k++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = $urandom;
      awready = (k == aw); wready = (k == w); arready = (k == a);
      bvalid = wr && !b_done && (k >= b); bresp = resp;
      rvalid = !wr && !r_done && (k >= r); rdata_in = rd; rresp = resp;
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (arvalid && arready) ar_hs++;
      if (bvalid && bready) begin b_hs++; b_done = 1'b1; end
      if (rvalid && rready) begin r_hs++; r_done = 1'b1; end
      if (k == rst_at) begin
        check("rready_before_reset", {31'd0, rready}, 32'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        q.delete();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        return;
      end
    end
    @(negedge clk);
    clear_inputs();
    if (!to) begin
      if (wr) begin
        check("aw_hs", aw_hs, 32'd1);
        check("w_hs", w_hs, 32'd1);
        check("b_hs", b_hs, 32'd1);
        check("wr_no_read_hs", ar_hs + r_hs, 32'd0);
      end else begin
        check("ar_hs", ar_hs, 32'd1);
        check("r_hs", r_hs, 32'd1);
        check("rd_no_write_hs", aw_hs + w_hs + b_hs, 32'd0);
      end
    end
  endtask

  initial begin
    bit wr;
    int aw, w, db, a, dr, m;
    clear_inputs();
    cmd_write = 1'b0; cmd_addr = 7'd0; cmd_wdata = 32'd0;
    bresp = 2'd0; rresp = 2'd0; rdata_in = 32'd0;
    #2 rst = 1'b1;
    #1;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_rsp", {rsp_rdata[29:0], rsp_valid, rsp_timeout}, 32'd0);
    check("reset_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check("reset_handshakes", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("reset_addr", {18'd0, awaddr, araddr}, 32'd0);
    check("reset_wdata", wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("cmd_ready_before_first_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);
    chk_en = 1'b1;

    // Plain write with ready slave
    run_txn(1'b1, 7'h54, 32'h0000_1234, 1, 1, 2, 0, 0, 2'b00, 32'd0, 0);
    #2;
    check("wr_latency", last_cyc - last_acc, 32'd2);
    check("wr_resp", {29'd0, last_to, last_resp}, 32'd0);

    // Read, data three cycles after address handshake
    run_txn(1'b0, 7'h44, 32'd0, 0, 0, 0, 1, 4, 2'b00, 32'h11A6_EBF8, 0);
    #2;
    check("rd_latency", last_cyc - last_acc, 32'd4);
    check("rd_rdata", last_rdata, 32'h11A6_EBF8);
    check("rd_resp", {29'd0, last_to, last_resp}, 32'd0);

    // WREADY two cycles ahead of AWREADY
    run_txn(1'b1, 7'h10, 32'hCAFE_0001, 3, 1, 4, 0, 0, 2'b01, 32'd0, 0);
    #2;
    check("split_latency", last_cyc - last_acc, 32'd4);
    check("split_resp", {30'd0, last_resp}, 32'd1);

    // Slave never accepts the read address
    run_txn(1'b0, 7'h20, 32'd0, 0, 0, 0, 1000, 1001, 2'b00, 32'hDEAD_BEEF, 0);
    #2;
    check("to_latency", last_cyc - last_acc, 32'd16);
    check("to_flag_resp", {29'd0, last_to, last_resp}, 32'b110);
    check("to_rdata", last_rdata, 32'd0);
    check("to_arvalid_after", {31'd0, arvalid}, 32'd0);

    // Reset while waiting for read data, then a normal read
    run_txn(1'b0, 7'h30, 32'd0, 0, 0, 0, 1, 10, 2'b00, 32'h1111_2222, 3);
    run_txn(1'b0, 7'h31, 32'd0, 0, 0, 0, 2, 3, 2'b11, 32'h3333_4444, 0);
    #2;
    check("post_reset_latency", last_cyc - last_acc, 32'd3);
    check("post_reset_rdata", last_rdata, 32'h3333_4444);
    check("post_reset_resp", {29'd0, last_to, last_resp}, 32'b011);

    // Completion exactly on the timeout edge wins
    run_txn(1'b0, 7'h05, 32'd0, 0, 0, 0, 10, 16, 2'b10, 32'h5555_AAAA, 0);
    #2;
    check("edge_rd_to_flag", {31'd0, last_to}, 32'd0);
    check("edge_rd_rdata", last_rdata, 32'h5555_AAAA);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      aw = $urandom_range(1, 12); w = $urandom_range(1, 12); db = $urandom_range(1, 8);
      a = $urandom_range(1, 18); dr = $urandom_range(1, 6);
      m = (aw > w) ? aw : w;
      if (wr) run_txn(1'b1, 7'($urandom), $urandom, aw, w, m + db, 0, 0, 2'($urandom), $urandom, 0);
      else    run_txn(1'b0, 7'($urandom), $urandom, 0, 0, 0, a, a + dr, 2'($urandom), $urandom, 0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
